multi_cycle_divider: RTL and testbench

- Iterative 32-bit integer divider that performs the inverse of the ALU's multiply function.
- Sits beside the ALU in the EX stage of the 5-stage pipeline.
- Accepts a start pulse with operands, computes quotient and remainder over multiple cycles with a radix-2 restoring algorithm, then returns a one-cycle done pulse.
- The hazard unit holds the pipeline while busy is high.

---
 rtl/multi_cycle_divider.sv | 161 ++++++++++++++++
 tb/tb_multi_cycle_divider.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_divider.sv
// Iterative radix-2 restoring divider: signed/unsigned 32-bit quotient and remainder.
module multi_cycle_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign_mode,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0]  dvd_q, dvd_d;     // dividend magnitude, becomes quotient
    logic [WIDTH-1:0]  dsr_q, dsr_d;     // divisor magnitude
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              dz_q, dz_d;

    logic              busy_d, done_d, dz_out_d;
    logic [WIDTH-1:0]  quot_d, rmd_d;

    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    rem_sh;
    logic              fits;
    logic [WIDTH-1:0]  diff;

    // Operand signs/magnitudes and the trial subtraction for one iteration.
    always_comb begin
        a_neg  = sign_mode & dividend[WIDTH-1];
        b_neg  = sign_mode & divisor[WIDTH-1];
        a_mag  = a_neg ? WIDTH'(~dividend + WIDTH'(1)) : dividend;
        b_mag  = b_neg ? WIDTH'(~divisor + WIDTH'(1)) : divisor;
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        fits   = (rem_sh >= {1'b0, dsr_q});
        diff   = WIDTH'(rem_sh - {1'b0, dsr_q});
    end

    // Next-state, datapath and output-register logic; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        quot_d   = quotient;
        rmd_d    = remainder;
        dz_out_d = div_by_zero;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            dvd_d   = ALL_ONES;
                            rem_d   = dividend;
                            q_neg_d = 1'b0;
                            r_neg_d = 1'b0;
                            dz_d    = 1'b1;
                            state_d = DONE;
                        end else if (sign_mode && dividend == MIN_NEG && divisor == ALL_ONES) begin
                            dvd_d   = MIN_NEG;
                            rem_d   = '0;
                            q_neg_d = 1'b0;
                            r_neg_d = 1'b0;
                            dz_d    = 1'b0;
                            state_d = DONE;
                        end else begin
                            dvd_d   = a_mag;
                            dsr_d   = b_mag;
                            rem_d   = '0;
                            q_neg_d = a_neg ^ b_neg;
                            r_neg_d = a_neg;
                            dz_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    rem_d = fits ? diff : rem_sh[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], fits};
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    if (cnt_q == LAST_IT) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    quot_d   = q_neg_q ? WIDTH'(~dvd_q + WIDTH'(1)) : dvd_q;
                    rmd_d    = r_neg_q ? WIDTH'(~rem_q + WIDTH'(1)) : rem_q;
                    dz_out_d = dz_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == CALC);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_q        <= dz_d;
            busy        <= busy_d;
            done        <= done_d;
            quotient    <= quot_d;
            remainder   <= rmd_d;
            div_by_zero <= dz_out_d;
        end
    end

endmodule

// File: tb/tb_multi_cycle_divider.sv
// Directed bench for multi_cycle_divider with a timeline/arithmetic reference model.
module tb_multi_cycle_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sign_mode, flush;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    multi_cycle_divider #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sign_mode(sign_mode), .flush(flush),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: what a divide must return, independent of how it is computed.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic dz, output logic fast);
        dz = 1'b0;
        fast = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1; fast = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; fast = 1'b1;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Timeline model: cycles remaining until done, with the expected visible outputs.
    int          m_left;
    logic [31:0] pq, pr;
    logic        pdz, pfast;
    logic        exp_busy, exp_done, exp_dz;
    logic [31:0] exp_q, exp_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; exp_busy = 0; exp_done = 0; exp_q = 0; exp_r = 0; exp_dz = 0;
        end else begin
            exp_done = 0;
            if (flush) begin
                m_left = 0;
                exp_busy = 0;
            end else if (m_left == 0) begin
                if (start) begin
                    ref_div(dividend, divisor, sign_mode, pq, pr, pdz, pfast);
                    m_left   = pfast ? 1 : 33;
                    exp_busy = !pfast;
                end
            end else begin
                m_left--;
                exp_busy = (m_left >= 2);
                if (m_left == 0) begin
                    exp_done = 1; exp_q = pq; exp_r = pr; exp_dz = pdz;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("quotient", quotient, exp_q);
        chk("remainder", remainder, exp_r);
        chk("div_by_zero", 32'(div_by_zero), 32'(exp_dz));
    end

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int lat_exp, input logic [31:0] qe, input logic [31:0] re,
                          input logic dze);
        int lat;
        @(negedge clk);
        dividend = a; divisor = b; sign_mode = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("lit_quotient", quotient, qe);
        chk("lit_remainder", remainder, re);
        chk("lit_dz", 32'(div_by_zero), 32'(dze));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; sign_mode = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        #2;
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned and signed basic divides
        do_div(32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
        do_div(32'hFFFF_FF9C, 32'd7, 1'b1, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        do_div(32'd100, 32'hFFFF_FFF9, 1'b1, 33, 32'hFFFF_FFF2, 32'd2, 1'b0);

        // Divide by zero, both modes
        do_div(32'h1234_5678, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        do_div(32'h1234_5678, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);

        // Signed overflow fast path, then the same operands unsigned
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'h8000_0000, 32'd0, 1'b0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 32'd0, 32'h8000_0000, 1'b0);

        // Ignored start while busy, then flush mid-calculation
        @(negedge clk);
        dividend = 32'hFFFF_FFFF; divisor = 32'd1; sign_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        dividend = 32'd5; divisor = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_quotient", quotient, 32'd0);
        chk("flush_remainder", remainder, 32'h8000_0000);
        repeat (40) @(negedge clk);
        chk("flush_no_done", 32'(done), 32'd0);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);

        // Start and flush in the same idle cycle: start dropped
        @(negedge clk);
        dividend = 32'd10; divisor = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("sf_busy", 32'(busy), 32'd0);
        chk("sf_quotient", quotient, 32'hFFFF_FFFF);

        // Asynchronous reset mid-calculation
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_quotient", quotient, 32'd0);
        chk("arst_remainder", remainder, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_div(32'd9, 32'd3, 1'b0, 33, 32'd3, 32'd0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
